// File: rtl/irq_encoder_8to3_pkg.sv
// Shared constants and types for the 8-to-3 interrupt request encoder.
// Request lines are active low; the synchroniser idles at all-ones.
package irq_enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Inactive level for the synchroniser chains, so reset release never looks like a falling edge
    localparam logic [N_REQ-1:0] SYNC_RST = {N_REQ{1'b1}};

    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] idx);
        logic [N_REQ-1:0] mask;
        mask = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
        return mask;
    endfunction

endpackage

// File: rtl/irq_encoder_8to3_if.sv
// Request/acknowledge bundle between event sources, the encoder and its consumer.
// The master side drives requests, enable and acknowledge; the encoder is the slave.
interface irq_encoder_8to3_if import irq_enc_pkg::*; ();

    logic [N_REQ-1:0]  req_n;
    logic              ei_n;
    logic              ack;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              gs_n;
    logic              eo_n;

    modport master (
        output req_n,
        output ei_n,
        output ack,
        input  code,
        input  valid,
        input  gs_n,
        input  eo_n
    );

    modport slave (
        input  req_n,
        input  ei_n,
        input  ack,
        output code,
        output valid,
        output gs_n,
        output eo_n
    );

endinterface

// File: rtl/irq_encoder_8to3_prio_enc.sv
// Combinational 8-to-3 priority encoder, active-high inputs, bit 7 wins.
// Equivalent to a 74LS148 with the polarities flipped to positive logic.
module prio_enc_8to3 import irq_enc_pkg::*; (
    input  logic [N_REQ-1:0]  pending,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Ascending scan so the highest set bit is the last one written
        for (int i = 0; i < N_REQ; i++) begin
            if (pending[i]) begin
                idx = CODE_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_encoder_8to3.sv
// Synchronises eight active-low request lines, latches their falling edges as
// pending requests and presents the highest one as a held code until acknowledged.
module irq_encoder_8to3 import irq_enc_pkg::*; #(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    irq_encoder_8to3_if.slave bus
);

    logic [SYNC_STAGES-1:0][N_REQ-1:0] sync_q;
    logic [N_REQ-1:0]                  sync_last_q;
    logic [N_REQ-1:0]                  fall;

    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [N_REQ-1:0]  clr_mask;
    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;

    logic [CODE_W-1:0] prio_idx;
    logic              prio_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= {SYNC_STAGES{SYNC_RST}};
            sync_last_q <= SYNC_RST;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.req_n};
            sync_last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // One extra flop past the chain gives the edge detector its previous sample
    assign fall = sync_last_q & ~sync_q[SYNC_STAGES-1];

    prio_enc_8to3 u_prio (
        .pending (pending_q),
        .idx     (prio_idx),
        .any     (prio_any)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        valid_d  = valid_q;
        clr_mask = '0;
        unique case (state_q)
            IDLE: begin
                if (!bus.ei_n && prio_any) begin
                    code_d  = prio_idx;
                    valid_d = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (bus.ack) begin
                    clr_mask = onehot(code_q);
                    valid_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh edge arriving as its bit is acknowledged stays pending
    assign pending_d = (pending_q & ~clr_mask) | fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
        end
    end

    assign bus.code  = code_q;
    assign bus.valid = valid_q;
    assign bus.gs_n  = ~(~bus.ei_n & ((|pending_q) | valid_q));
    assign bus.eo_n  = ~(~bus.ei_n & ~(|pending_q) & ~valid_q);

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Directed bench for irq_encoder_8to3: reset, single request, priority,
// set-wins collision, enable gating and asynchronous reset during SHOW.
module tb_irq_encoder_8to3;

    logic clk;
    logic rst_n;
    int   total_cnt;
    int   pass_cnt;
    int   fail_cnt;
    logic seen_flag;

    irq_encoder_8to3_if bus ();

    irq_encoder_8to3 #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        rst_n     = 1'b0;
        bus.req_n = 8'hFF;
        bus.ei_n  = 1'b0;
        bus.ack   = 1'b0;

        // Reset then idle
        #1;
        chk("rst_valid", 8'(bus.valid), 8'h0);
        chk("rst_code",  8'(bus.code),  8'h0);
        chk("rst_gs_n",  8'(bus.gs_n),  8'h1);
        chk("rst_eo_n",  8'(bus.eo_n),  8'h0);
        ticks(3);
        rst_n = 1'b1;
        seen_flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.valid !== 1'b0) seen_flag = 1'b1;
        end
        chk("idle_20_no_valid", 8'(seen_flag), 8'h0);
        $display("reset/idle: valid=%0b code=%0d", bus.valid, bus.code);

        // Single request on bit 5: valid exactly 3 cycles after first sample
        bus.req_n = 8'hDF;
        ticks(3);
        chk("single_not_yet", 8'(bus.valid), 8'h0);
        chk("single_gs_pend", 8'(bus.gs_n),  8'h0);
        tick();
        chk("single_valid", 8'(bus.valid), 8'h1);
        chk("single_code",  8'(bus.code),  8'h5);
        ticks(3);
        chk("single_hold_valid", 8'(bus.valid), 8'h1);
        chk("single_hold_code",  8'(bus.code),  8'h5);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("single_ack_valid", 8'(bus.valid), 8'h0);
        chk("single_ack_eo_n",  8'(bus.eo_n),  8'h0);
        seen_flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.valid !== 1'b0) seen_flag = 1'b1;
        end
        chk("single_no_repeat", 8'(seen_flag), 8'h0);
        $display("single: code 5 presented and acknowledged");
        bus.req_n = 8'hFF;
        ticks(4);

        // Bits 2 and 6 together, then bit 7 during SHOW
        bus.req_n = 8'hBB;
        ticks(4);
        chk("prio_first_valid", 8'(bus.valid), 8'h1);
        chk("prio_first_code",  8'(bus.code),  8'h6);
        bus.req_n = 8'h3B;
        ticks(5);
        chk("prio_no_preempt", 8'(bus.code), 8'h6);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("prio_ack6_valid", 8'(bus.valid), 8'h0);
        tick();
        chk("prio_second_valid", 8'(bus.valid), 8'h1);
        chk("prio_second_code",  8'(bus.code),  8'h7);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
        chk("prio_third_valid", 8'(bus.valid), 8'h1);
        chk("prio_third_code",  8'(bus.code),  8'h2);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("prio_done_eo_n", 8'(bus.eo_n), 8'h0);
        $display("priority: codes 6, 7, 2 in order");
        bus.req_n = 8'hFF;
        ticks(4);

        // Set-wins: new edge on bit 3 lands in pending on the ack cycle
        bus.req_n = 8'hF7;
        ticks(4);
        chk("coll_first_code", 8'(bus.code), 8'h3);
        bus.req_n = 8'hFF;
        ticks(3);
        bus.req_n = 8'hF7;
        ticks(2);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("coll_ack_valid", 8'(bus.valid), 8'h0);
        chk("coll_still_pend", 8'(bus.gs_n), 8'h0);
        tick();
        chk("coll_re_valid", 8'(bus.valid), 8'h1);
        chk("coll_re_code",  8'(bus.code),  8'h3);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.req_n = 8'hFF;
        ticks(4);
        chk("coll_clear_eo_n", 8'(bus.eo_n), 8'h0);
        $display("collision: code 3 re-presented after ack");

        // Enable gating on bit 4
        bus.ei_n  = 1'b1;
        bus.req_n = 8'hEF;
        ticks(6);
        chk("en_gate_valid", 8'(bus.valid), 8'h0);
        chk("en_gate_gs_n",  8'(bus.gs_n),  8'h1);
        chk("en_gate_eo_n",  8'(bus.eo_n),  8'h1);
        bus.ei_n = 1'b0;
        #1;
        chk("en_open_gs_n", 8'(bus.gs_n), 8'h0);
        tick();
        chk("en_open_valid", 8'(bus.valid), 8'h1);
        chk("en_open_code",  8'(bus.code),  8'h4);
        bus.ei_n = 1'b1;
        tick();
        chk("en_rise_hold", 8'(bus.valid), 8'h1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("en_rise_ack", 8'(bus.valid), 8'h0);
        bus.ei_n  = 1'b0;
        bus.req_n = 8'hFF;
        ticks(4);
        $display("enable: code 4 gated then presented");

        // Asynchronous reset during SHOW with code 1
        bus.req_n = 8'hFD;
        ticks(4);
        chk("areset_pre_code", 8'(bus.code), 8'h1);
        #2;
        rst_n     = 1'b0;
        bus.req_n = 8'hFC;
        #1;
        chk("areset_valid", 8'(bus.valid), 8'h0);
        chk("areset_code",  8'(bus.code),  8'h0);
        chk("areset_gs_n",  8'(bus.gs_n),  8'h1);
        ticks(2);
        bus.req_n = 8'hFF;
        tick();
        #3;
        rst_n = 1'b1;
        seen_flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.valid !== 1'b0 || bus.gs_n !== 1'b1) seen_flag = 1'b1;
        end
        chk("areset_no_spurious", 8'(seen_flag), 8'h0);
        $display("async reset: cleared, no spurious valid");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
